// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial addition controller. Drives an external 1-bit
//               full-adder cell LSB-first over WIDTH cycles, keeps the
//               running carry in a register and assembles the sum word.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c1,
    input  logic             fa_s,
    input  logic             fa_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_s_sh;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   w_s_next;

    // Next sum register value: the new bit from the cell enters at the MSB so
    // that after WIDTH shifts bit 0 of the result sits at bit 0.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_s_next = fa_s;
        end else begin : g_wn
            assign w_s_next = {fa_s, r_s_sh[WIDTH-1:1]};
        end
    endgenerate

    // Controller FSM with operand/sum shifting and registered status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Cell outputs settle within this cycle; capture them now.
                    r_s_sh  <= w_s_next;
                    r_carry <= fa_c;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The cell inputs are forced low whenever no addition is in progress
    assign fa_a  = (r_state == S_RUN) & r_a_sh[0];
    assign fa_b  = (r_state == S_RUN) & r_b_sh[0];
    assign fa_c1 = (r_state == S_RUN) & r_carry;

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_s_sh;
    assign cout = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=8 and
//               WIDTH=1 instances) with an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       fa_a, fa_b, fa_c1, fa_s, fa_c;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start1, a1, b1, cin1;
    logic       fa1_a, fa1_b, fa1_c1, fa1_s, fa1_c;
    logic       busy1, done1, sum1, cout1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Full-adder cells
    assign fa_s   = fa_a ^ fa_b ^ fa_c1;
    assign fa_c   = (fa_a & fa_b) | (fa_a & fa_c1) | (fa_b & fa_c1);
    assign fa1_s  = fa1_a ^ fa1_b ^ fa1_c1;
    assign fa1_c  = (fa1_a & fa1_b) | (fa1_a & fa1_c1) | (fa1_b & fa1_c1);

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c1(fa_c1), .fa_s(fa_s), .fa_c(fa_c),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .fa_a(fa1_a), .fa_b(fa1_b), .fa_c1(fa1_c1), .fa_s(fa1_s), .fa_c(fa1_c),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: cycles remaining in the current add and the result
    int          m_left = 0;
    logic        m_valid = 1'b0;
    logic        m_done = 1'b0;
    logic [7:0]  m_sum = '0;
    logic        m_cout = 1'b0;
    logic [63:0] m_a = '0, m_b = '0;
    logic        m_cin = 1'b0;
    logic [8:0]  m_res;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_done  = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else if (m_valid) begin
            if (m_left == 0) begin
                m_done = 1'b0;
                if (start) begin
                    m_left = 8;
                    m_a    = 64'(a);
                    m_b    = 64'(b);
                    m_cin  = cin;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_res  = 9'(m_a + m_b + 64'(m_cin));
                    m_sum  = m_res[7:0];
                    m_cout = m_res[8];
                    m_done = 1'b1;
                end
            end
        end
    end

    // Compare process: every cycle once the model has seen reset
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_done));
            if (m_left == 0) begin
                check("fa_a_idle", 64'(fa_a), 64'd0);
                check("fa_b_idle", 64'(fa_b), 64'd0);
                check("fa_c1_idle", 64'(fa_c1), 64'd0);
                check("sum_hold", 64'(sum), 64'(m_sum));
                check("cout_hold", 64'(cout), 64'(m_cout));
            end else begin
                int k;
                logic [63:0] mask;
                logic [63:0] part;
                k    = 8 - m_left;
                mask = (64'd1 << k) - 64'd1;
                part = ((m_a & mask) + (m_b & mask) + 64'(m_cin)) >> k;
                check("fa_a_bit", 64'(fa_a), 64'(m_a[k]));
                check("fa_b_bit", 64'(fa_b), 64'(m_b[k]));
                check("fa_c1_carry", 64'(fa_c1), 64'(part[0]));
            end
        end
    end

    // One add; optional ignored start pulse at a given cycle into RUN
    task automatic run_add(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                           input int inject_at,
                           output logic [7:0] rs, output logic rc,
                           output int lat, output int bc);
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb; cin = tc;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        bc  = 0;
        while (!done && lat < 40) begin
            bc += int'(busy);
            @(posedge clk); #1;
            lat++;
            start = 1'b0;
            if (lat == inject_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
            end
        end
        rs = sum;
        rc = cout;
    endtask

    logic [7:0] rs;
    logic       rc;
    int         lat, bc, seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_fa", 64'({fa_a, fa_b, fa_c1}), 64'd0);
        rst_n = 1'b1;

        // 0x5A + 0x3C
        run_add(8'h5A, 8'h3C, 1'b0, 0, rs, rc, lat, bc);
        check("t1_sum", 64'(rs), 64'h96);
        check("t1_cout", 64'(rc), 64'd0);
        check("t1_lat", 64'(lat), 64'd9);
        check("t1_busy_cycles", 64'(bc), 64'd8);
        @(posedge clk); #1;
        check("t1_done_pulse", 64'(done), 64'd0);

        // Carry ripple through all bits
        run_add(8'hFF, 8'h01, 1'b0, 0, rs, rc, lat, bc);
        check("t2_sum", 64'(rs), 64'h00);
        check("t2_cout", 64'(rc), 64'd1);
        run_add(8'hFF, 8'hFF, 1'b1, 0, rs, rc, lat, bc);
        check("t3_sum", 64'(rs), 64'hFF);
        check("t3_cout", 64'(rc), 64'd1);

        // start during RUN is ignored
        run_add(8'h10, 8'h20, 1'b0, 4, rs, rc, lat, bc);
        check("t4_sum", 64'(rs), 64'h30);
        check("t4_cout", 64'(rc), 64'd0);
        check("t4_lat", 64'(lat), 64'd9);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen += int'(done) + int'(busy);
        end
        check("t4_no_queued_start", 64'(seen), 64'd0);

        // Reset aborts an add in progress
        @(posedge clk); #1;
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_sum", 64'(sum), 64'd0);
        check("t5_cout", 64'(cout), 64'd0);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            seen += int'(done);
        end
        check("t5_no_done", 64'(seen), 64'd0);

        // Back-to-back: start held through DONE
        @(posedge clk); #1;
        start = 1'b1; a = 8'h01; b = 8'h02; cin = 1'b0;
        @(posedge clk); #1;
        a = 8'h80; b = 8'h80;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t6_first_sum", 64'(sum), 64'h03);
        check("t6_first_lat", 64'(lat), 64'd9);
        @(posedge clk); #1;
        start = 1'b0;
        check("t6_rerun_busy", 64'(busy), 64'd1);
        check("t6_rerun_done", 64'(done), 64'd0);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("t6_sum", 64'(sum), 64'h00);
        check("t6_cout", 64'(cout), 64'd1);
        check("t6_lat", 64'(lat), 64'd9);

        // WIDTH=1 instance: 1 + 1 + 1
        @(posedge clk); #1;
        start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        check("w1_busy", 64'(busy1), 64'd1);
        check("w1_done_early", 64'(done1), 64'd0);
        check("w1_fa", 64'({fa1_a, fa1_b, fa1_c1}), 64'h7);
        @(posedge clk); #1;
        check("w1_busy_end", 64'(busy1), 64'd0);
        check("w1_done", 64'(done1), 64'd1);
        check("w1_sum", 64'(sum1), 64'd1);
        check("w1_cout", 64'(cout1), 64'd1);
        @(posedge clk); #1;
        check("w1_done_pulse", 64'(done1), 64'd0);
        check("w1_sum_hold", 64'(sum1), 64'd1);
        check("w1_fa_idle", 64'({fa1_a, fa1_b, fa1_c1}), 64'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
